spectrogram_frame_receiver: RTL and testbench
=============================================

# spectrogram_frame_receiver

Deserializer for the spectrogram extractor's two-lane serial readout stream. It recovers the 32-bit event timestamp and the stream of 3-bit encoded channel samples for both channels, then presents them as parallel words with valid strobes. It sits at the far end of the serial link, on the host/FPGA side, and forms the receiving end of the extractor's readout protocol.

## Interface

**Parameters**
- `MAX_SAMPLES`, default 512: maximum number of sample pairs accepted per frame (two 256-entry banks).

**Ports**
- `clk`, input, 1: serial readout clock; same clock that shifts the transmitter.
- `reset`, input, 1: synchronous, active-high.
- `serial_in`, input, 2: lane 0 carries the timestamp, then ch1 samples; lane 1 carries ch2 samples.
- `sending_data`, input, 1: frame envelope; high for the whole frame.
- `bit_valid`, input, 1: one bit per lane is present this cycle.
- `event_time`, output, 32: last received timestamp.
- `time_valid`, output, 1: one-cycle pulse when `event_time` is updated.
- `sample_ch1`, output, 3: last ch1 sample.
- `sample_ch2`, output, 3: last ch2 sample.
- `sample_valid`, output, 1: one-cycle pulse when a sample pair is updated.
- `sample_idx`, output, 9: index of the current sample within the frame, starting at 0.
- `sample_count`, output, 10: number of samples in the last finished frame; held between frames.
- `frame_done`, output, 1: one-cycle pulse on a clean frame end.
- `frame_error`, output, 1: one-cycle pulse on a truncated or overflowing frame.
- `busy`, output, 1: high in every state except IDLE.

## Operation

**Bit acceptance**
- A bit is accepted only in a cycle where `sending_data=1` and `bit_valid=1`.
- `bit_valid` while `sending_data=0` is ignored.
- Bits are sent MSB first.

**States**
- **IDLE**
  - `sending_data=1` → TIME, with the bit counter cleared.
  - A bit present in that same cycle is accepted as timestamp bit 31.
- **TIME**
  - Shift `serial_in[0]` into a 32-bit register; `serial_in[1]` is don't-care.
  - On the 32nd accepted bit → DATA, with the sample counter cleared.
  - `sending_data=0` before the 32nd bit → `frame_error`, then IDLE. `event_time` is not updated.
- **DATA**
  - Each lane shifts into its own 3-bit register.
  - On every 3rd accepted bit, `sample_ch1` and `sample_ch2` update, `sample_idx` takes the current count, and the count increments.
  - `sending_data=0` with a partial sample (1 or 2 bits held) → `frame_error`, then IDLE.
  - `sending_data=0` with no partial sample → `frame_done`, `sample_count` updated to the count (0 is legal), then IDLE.
  - A bit accepted when count = `MAX_SAMPLES` → `frame_error`, then DRAIN.
- **DRAIN**
  - All bits are ignored.
  - `sending_data=0` → IDLE.
  - No further pulses are issued.

**Reset**
- All outputs are cleared to 0: `event_time`, samples, `sample_idx`, `sample_count`, all strobes.
- State goes to DRAIN, so a frame already in flight when reset is released is discarded rather than misparsed.
- `busy` reads 1 after reset until `sending_data` is seen low.

**Simultaneous events**
- `sending_data` falling in the same cycle as `bit_valid`: the bit is not accepted, because acceptance requires `sending_data=1`.
- Count arithmetic is 10-bit unsigned and never wraps, since overflow is caught at `MAX_SAMPLES`.

## Timing

- All outputs are registered.
- `time_valid` pulses one cycle after the cycle that accepts timestamp bit 0 (the LSB). `event_time` is valid from that same cycle.
- `sample_valid` pulses one cycle after the 3rd bit of a sample is accepted, together with the new `sample_ch1`, `sample_ch2` and `sample_idx`.
- `frame_done` and `frame_error` pulse one cycle after the cycle in which `sending_data=0` is sampled. `sample_count` changes in that same cycle.
- `frame_done` and `frame_error` are never high together. At most one of them fires per frame.
- `busy` goes high the cycle after `sending_data` is first seen high in IDLE, and goes low the cycle after the return to IDLE.
- Back-to-back frames: one `sending_data=0` cycle between frames is sufficient.
- Throughput: one bit per lane per cycle, so one sample every 3 cycles once in DATA.

## Test plan

1. **Clean frame.** Timestamp 0xA5C3_0F81, then samples (ch1,ch2) = (1,6), (7,0), (3,3), `bit_valid` continuous, then `sending_data` low.
   - `time_valid` once, with `event_time`=0xA5C30F81.
   - Three `sample_valid` pulses with idx 0, 1, 2 and matching values.
   - `frame_done` with `sample_count`=3.
2. **Gapped `bit_valid`.** Same frame as scenario 1, with `bit_valid` low on every other cycle.
   - Identical outputs to scenario 1; only the strobe spacing changes.
3. **Truncated frames.**
   - Drop `sending_data` after 20 timestamp bits → `frame_error`, no `time_valid`, `event_time` unchanged.
   - Drop it after 2 samples plus 1 bit → `frame_error`, `sample_count` unchanged.
4. **Overflow.** Send 513 samples with `MAX_SAMPLES`=512.
   - 512 `sample_valid` pulses, the last with idx 511.
   - `frame_error` on the first bit of sample 513.
   - No further strobes until `sending_data` falls.
   - The next frame is received cleanly.
5. **Reset mid-frame.** Assert `reset` during DATA, release it while `sending_data=1`.
   - All outputs 0 and `busy`=1, with no strobes for the rest of that frame.
   - After `sending_data` falls, the next frame decodes correctly.
6. **Empty frame.** 32 timestamp bits, then `sending_data` low immediately.
   - `time_valid`, then `frame_done` with `sample_count`=0.

Source files
------------

// File: rtl/spectrogram_frame_receiver.sv
// spectrogram_frame_receiver
//   Receiving end of the spectrogram extractor's two-lane serial readout.
//   A frame is bracketed by sending_data. It carries a 32-bit timestamp on
//   lane 0, then a stream of 3-bit sample pairs (ch1 on lane 0, ch2 on
//   lane 1). All data is sent MSB first.
//
// Ports
//   clk          serial readout clock
//   reset        synchronous, active-high; parks the FSM in DRAIN
//   serial_in    [0]=timestamp/ch1 lane, [1]=ch2 lane
//   sending_data frame envelope
//   bit_valid    one bit per lane present this cycle
//   event_time   last complete timestamp, qualified by time_valid
//   sample_ch1/2 last sample pair, qualified by sample_valid
//   sample_idx   index of that pair within the frame
//   sample_count number of pairs in the last cleanly finished frame
//   frame_done   pulse on a clean frame end
//   frame_error  pulse on a truncated or overflowing frame
//   busy         high in every state except IDLE
module spectrogram_frame_receiver #(
  parameter int MAX_SAMPLES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  serial_in,
  input  logic        sending_data,
  input  logic        bit_valid,
  output logic [31:0] event_time,
  output logic        time_valid,
  output logic [2:0]  sample_ch1,
  output logic [2:0]  sample_ch2,
  output logic        sample_valid,
  output logic [8:0]  sample_idx,
  output logic [9:0]  sample_count,
  output logic        frame_done,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [9:0] MAX_CNT = 10'(MAX_SAMPLES);

  typedef enum logic [1:0] {IDLE, TIME, DATA, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [30:0] time_shift_reg;    // only 31 bits held; bit 0 arrives with the load
  logic [4:0]  bit_cnt_reg;
  logic [1:0]  phase_reg;         // bits already held of the current sample
  logic [9:0]  count_reg;
  logic [1:0]  lane_hold_reg [2]; // top two bits of the sample in flight, per lane

  logic accept;
  logic clear_bits, time_shift_en, time_load;
  logic lane_shift_en, sample_load, done_set, err_set;

  assign accept = sending_data & bit_valid;
  assign busy   = (state_reg != IDLE);

  always_comb begin
    state_next    = state_reg;
    clear_bits    = 1'b0;
    time_shift_en = 1'b0;
    time_load     = 1'b0;
    lane_shift_en = 1'b0;
    sample_load   = 1'b0;
    done_set      = 1'b0;
    err_set       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sending_data) begin
          state_next    = TIME;
          clear_bits    = 1'b1;
          // A bit arriving together with the envelope edge is timestamp bit 31.
          time_shift_en = accept;
        end
      end
      TIME: begin
        if (!sending_data) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (accept) begin
          time_shift_en = 1'b1;
          if (bit_cnt_reg == 5'd31) begin
            time_load  = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (!sending_data) begin
          if (phase_reg != 2'd0) err_set  = 1'b1;
          else                   done_set = 1'b1;
          state_next = IDLE;
        end else if (accept) begin
          if (count_reg == MAX_CNT) begin
            err_set    = 1'b1;
            state_next = DRAIN;
          end else begin
            lane_shift_en = 1'b1;
            sample_load   = (phase_reg == 2'd2);
          end
        end
      end
      DRAIN: begin
        if (!sending_data) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= DRAIN;
      time_shift_reg <= '0;
      bit_cnt_reg    <= '0;
      phase_reg      <= '0;
      count_reg      <= '0;
      event_time     <= '0;
      time_valid     <= 1'b0;
      sample_ch1     <= '0;
      sample_ch2     <= '0;
      sample_valid   <= 1'b0;
      sample_idx     <= '0;
      sample_count   <= '0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      time_valid   <= time_load;
      sample_valid <= sample_load;
      frame_done   <= done_set;
      frame_error  <= err_set;

      if (clear_bits)         bit_cnt_reg <= {4'd0, time_shift_en};
      else if (time_shift_en) bit_cnt_reg <= bit_cnt_reg + 5'd1;

      if (time_shift_en) time_shift_reg <= {time_shift_reg[29:0], serial_in[0]};

      if (time_load) begin
        event_time <= {time_shift_reg, serial_in[0]};
        count_reg  <= '0;
        phase_reg  <= '0;
      end

      if (lane_shift_en) phase_reg <= (phase_reg == 2'd2) ? 2'd0 : phase_reg + 2'd1;

      if (sample_load) begin
        sample_ch1 <= {lane_hold_reg[0], serial_in[0]};
        sample_ch2 <= {lane_hold_reg[1], serial_in[1]};
        sample_idx <= count_reg[8:0];
        count_reg  <= count_reg + 10'd1;
      end

      if (done_set) sample_count <= count_reg;
    end
  end

  // Per-lane sample shift registers.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset)              lane_hold_reg[gi] <= '0;
        else if (lane_shift_en) lane_hold_reg[gi] <= {lane_hold_reg[gi][0], serial_in[gi]};
      end
    end
  endgenerate

endmodule

// File: tb/tb_spectrogram_frame_receiver.sv
// Directed bench for spectrogram_frame_receiver. Inputs are driven 1 time
// unit after the rising edge; outputs are observed on the falling edge by a
// monitor that logs strobes (with the cycle they appeared) for later checks.
module tb_spectrogram_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  serial_in;
  logic        sending_data;
  logic        bit_valid;
  logic [31:0] event_time;
  logic        time_valid;
  logic [2:0]  sample_ch1;
  logic [2:0]  sample_ch2;
  logic        sample_valid;
  logic [8:0]  sample_idx;
  logic [9:0]  sample_count;
  logic        frame_done;
  logic        frame_error;
  logic        busy;

  spectrogram_frame_receiver #(.MAX_SAMPLES(512)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .sending_data(sending_data), .bit_valid(bit_valid),
    .event_time(event_time), .time_valid(time_valid),
    .sample_ch1(sample_ch1), .sample_ch2(sample_ch2),
    .sample_valid(sample_valid), .sample_idx(sample_idx),
    .sample_count(sample_count), .frame_done(frame_done),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int c1;
    int c2;
    int cyc;
  } samp_t;

  samp_t       sq[$];
  int          exp_scyc[$];
  samp_t       mon_s;
  int          tv_cnt, tv_cyc, fd_cnt, fe_cnt, fe_cyc, both_cnt;
  logic [31:0] tv_val;
  int          last_drive_cyc;
  int          tests_run = 0;
  int          tests_failed = 0;

  always @(negedge clk) begin
    if (time_valid) begin
      tv_cnt++;
      tv_val = event_time;
      tv_cyc = cyc;
    end
    if (sample_valid) begin
      mon_s.idx = int'(sample_idx);
      mon_s.c1  = int'(sample_ch1);
      mon_s.c2  = int'(sample_ch2);
      mon_s.cyc = cyc;
      sq.push_back(mon_s);
    end
    if (frame_done) fd_cnt++;
    if (frame_error) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (frame_done && frame_error) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    tv_cnt = 0; fd_cnt = 0; fe_cnt = 0; both_cnt = 0;
    tv_cyc = -1; fe_cyc = -1;
    sq.delete();
    exp_scyc.delete();
  endtask

  task automatic drive_bit(input logic b0, input logic b1, input bit gap);
    if (gap) begin
      @(posedge clk); #1;
      sending_data = 1'b1; bit_valid = 1'b0; serial_in = 2'b11;
    end
    @(posedge clk); #1;
    sending_data = 1'b1; bit_valid = 1'b1; serial_in = {b1, b0};
    last_drive_cyc = cyc;
  endtask

  task automatic send_time(input logic [31:0] ts, input int nbits, input bit gap);
    for (int i = 0; i < nbits; i++) drive_bit(ts[31-i], 1'(i & 1), gap);
  endtask

  task automatic send_sample(input logic [2:0] c1, input logic [2:0] c2, input int nbits, input bit gap);
    for (int i = 0; i < nbits; i++) drive_bit(c1[2-i], c2[2-i], gap);
    if (nbits == 3) exp_scyc.push_back(last_drive_cyc + 1);
  endtask

  // Drops the envelope with bit_valid still high (those bits must be ignored),
  // then idles a few cycles so every resulting strobe has been logged.
  task automatic end_frame(input string tag);
    @(posedge clk); #1;
    sending_data = 1'b0; bit_valid = 1'b1; serial_in = 2'b11;
    repeat (3) @(posedge clk);
    #1 bit_valid = 1'b0;
    $display("[TB] frame %s: time_valid=%0d samples=%0d done=%0d error=%0d count=%0d",
             tag, tv_cnt, sq.size(), fd_cnt, fe_cnt, sample_count);
  endtask

  task automatic run_clean(input bit gap, input string tag);
    logic [2:0] c1v [3];
    logic [2:0] c2v [3];
    int exp_tv;
    c1v = '{3'd1, 3'd7, 3'd3};
    c2v = '{3'd6, 3'd0, 3'd3};
    clear_counts();
    send_time(32'hA5C3_0F81, 32, gap);
    exp_tv = last_drive_cyc + 1;
    for (int i = 0; i < 3; i++) send_sample(c1v[i], c2v[i], 3, gap);
    end_frame(tag);
    check({tag, " tv_cnt"}, tv_cnt, 1);
    check({tag, " event_time"}, tv_val, 32'hA5C3_0F81);
    check({tag, " tv_latency"}, tv_cyc, exp_tv);
    check({tag, " n_samples"}, sq.size(), 3);
    if (sq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("%s idx%0d", tag, i), sq[i].idx, i);
        check($sformatf("%s ch1_%0d", tag, i), sq[i].c1, c1v[i]);
        check($sformatf("%s ch2_%0d", tag, i), sq[i].c2, c2v[i]);
        check($sformatf("%s s_latency%0d", tag, i), sq[i].cyc, exp_scyc[i]);
      end
    end
    check({tag, " done"}, fd_cnt, 1);
    check({tag, " error"}, fe_cnt, 0);
    check({tag, " both"}, both_cnt, 0);
    check({tag, " sample_count"}, sample_count, 3);
    check({tag, " busy_idle"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sending_data = 1'b0; bit_valid = 1'b0; serial_in = 2'b00;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst event_time", event_time, 0);
    check("rst samples", {sample_ch1, sample_ch2, sample_idx}, 0);
    check("rst sample_count", sample_count, 0);
    check("rst strobes", {time_valid, sample_valid, frame_done, frame_error}, 0);
    check("rst busy", busy, 1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst busy", busy, 0);

    // 1: clean frame, 2: same frame with gapped bit_valid
    run_clean(1'b0, "clean");
    run_clean(1'b1, "gapped");

    // 3a: truncated inside the timestamp
    clear_counts();
    send_time(32'h1111_1111, 20, 1'b0);
    end_frame("trunc_time");
    check("trunc_time tv_cnt", tv_cnt, 0);
    check("trunc_time error", fe_cnt, 1);
    check("trunc_time done", fd_cnt, 0);
    check("trunc_time event_time", event_time, 32'hA5C3_0F81);

    // 3b: truncated inside a sample
    clear_counts();
    send_time(32'h1234_5678, 32, 1'b0);
    send_sample(3'd2, 3'd3, 3, 1'b0);
    send_sample(3'd6, 3'd4, 3, 1'b0);
    send_sample(3'd5, 3'd0, 1, 1'b0);
    end_frame("trunc_data");
    check("trunc_data event_time", tv_val, 32'h1234_5678);
    check("trunc_data n_samples", sq.size(), 2);
    check("trunc_data error", fe_cnt, 1);
    check("trunc_data done", fd_cnt, 0);
    check("trunc_data sample_count", sample_count, 3);

    // 4: overflow at 513 samples
    clear_counts();
    send_time(32'h0000_0513, 32, 1'b0);
    for (int i = 0; i < 512; i++) send_sample(3'(i % 8), 3'((i * 3) % 8), 3, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    check("ovf error_latency_ref", 1, 1 == 1 ? 1 : 0);
    tests_run--; // the line above is not a real comparison
    begin
      int exp_fe;
      exp_fe = last_drive_cyc + 1;
      for (int i = 0; i < 8; i++) drive_bit(1'(i & 1), 1'b1, 1'b0);
      end_frame("overflow");
      check("ovf error_latency", fe_cyc, exp_fe);
    end
    check("ovf n_samples", sq.size(), 512);
    if (sq.size() == 512) begin
      check("ovf first_idx", sq[0].idx, 0);
      check("ovf last_idx", sq[511].idx, 511);
      check("ovf last_ch1", sq[511].c1, 7);
      check("ovf last_ch2", sq[511].c2, 5);
      check("ovf mid_ch2", sq[100].c2, (100 * 3) % 8);
    end
    check("ovf error", fe_cnt, 1);
    check("ovf done", fd_cnt, 0);
    check("ovf sample_count", sample_count, 3);
    run_clean(1'b0, "after_ovf");

    // 6: empty frame
    clear_counts();
    send_time(32'hDEAD_BEEF, 32, 1'b0);
    end_frame("empty");
    check("empty tv_cnt", tv_cnt, 1);
    check("empty event_time", tv_val, 32'hDEAD_BEEF);
    check("empty done", fd_cnt, 1);
    check("empty error", fe_cnt, 0);
    check("empty n_samples", sq.size(), 0);
    check("empty sample_count", sample_count, 0);

    // 5: reset asserted during DATA, released while the frame continues
    clear_counts();
    send_time(32'h0BAD_F00D, 32, 1'b0);
    send_sample(3'd2, 3'd5, 3, 1'b0);
    send_sample(3'd4, 3'd1, 2, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_counts();
    @(negedge clk);
    check("midrst event_time", event_time, 0);
    check("midrst samples", {sample_ch1, sample_ch2, sample_idx}, 0);
    check("midrst sample_count", sample_count, 0);
    check("midrst busy", busy, 1);
    for (int i = 0; i < 12; i++) drive_bit(1'(i & 1), 1'((i >> 1) & 1), 1'b0);
    @(negedge clk);
    check("midrst busy_late", busy, 1);
    end_frame("reset_mid");
    check("midrst tv_cnt", tv_cnt, 0);
    check("midrst n_samples", sq.size(), 0);
    check("midrst strobes", fd_cnt + fe_cnt, 0);
    run_clean(1'b0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
